// File: rtl/huffman_byte_packer_if.sv
// Serial code-bit input and byte valid/ready output of the Huffman byte packer.
// master = packer side, slave = upstream/consumer side.
interface huffman_byte_packer_if;
    logic       bit_in;
    logic       bit_start;
    logic       bit_done;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic       byte_last;
    logic [3:0] byte_nbits;
    logic       overflow;
    logic       busy;

    modport master (
        input  bit_in, bit_start, bit_done, byte_ready,
        output byte_data, byte_valid, byte_last, byte_nbits, overflow, busy
    );

    modport slave (
        output bit_in, bit_start, bit_done, byte_ready,
        input  byte_data, byte_valid, byte_last, byte_nbits, overflow, busy
    );
endinterface

// File: rtl/huffman_byte_packer.sv
// Packs MSB-first code bits into bytes behind a FWFT FIFO; PACKER_CRC_EN appends a CRC-8 entry per packet.
// Byte valid one cycle after its final bit; upstream never stalls, so a full FIFO drops and flags overflow.
module huffman_byte_packer #(
    parameter int FIFO_DEPTH = 8,
    parameter bit PAD_BIT    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    huffman_byte_packer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic       last;
        logic [3:0] nbits;
        logic [7:0] data;
    } entry_t;

`ifdef PACKER_CRC_EN
    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, CRC} state_t;
`else
    typedef enum logic [0:0] {IDLE, COLLECT} state_t;
`endif

    state_t        state_q;
    logic [7:0]    sr_q;
    logic [3:0]    cnt_q;
    entry_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic       new_pkt;
    logic       take_bit;
    logic       done_now;
    logic       full_now;
    logic       dpush;
    logic [7:0] new_sr;
    logic [3:0] new_cnt;
    logic [7:0] aligned;
    logic       push;
    entry_t     push_entry;
    logic       fifo_vld;
    logic       fifo_full;
    logic       pop;
    logic       push_ok;
    entry_t     head;

    // Left-align n collected bits and fill the unused LSBs with PAD_BIT.
    function automatic logic [7:0] align_byte(input logic [7:0] sr, input logic [3:0] n);
        logic [7:0] mask;
        mask = PAD_BIT ? (8'hFF >> n) : 8'h00;
        return (sr << (4'd8 - n)) | mask;
    endfunction

`ifdef PACKER_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    always_comb begin
`ifdef PACKER_CRC_EN
        new_pkt = bus.bit_start && (state_q != FLUSH);
`else
        new_pkt = bus.bit_start;
`endif
        take_bit = new_pkt || (state_q == COLLECT);
        new_sr   = new_pkt ? {7'b0, bus.bit_in} : {sr_q[6:0], bus.bit_in};
        new_cnt  = new_pkt ? 4'd1 : cnt_q + 4'd1;
        done_now = take_bit && bus.bit_done;
        full_now = take_bit && (new_cnt == 4'd8);
        aligned  = align_byte(new_sr, new_cnt);
        dpush    = full_now || done_now;
        push     = dpush;
`ifdef PACKER_CRC_EN
        push_entry = {1'b0, new_cnt, aligned};
        // A 1-bit packet starting in the CRC cycle is parked in sr_q and pushed from FLUSH.
        if (state_q == CRC) begin
            push       = 1'b1;
            push_entry = {1'b1, 4'd8, crc_q};
        end else if (state_q == FLUSH) begin
            push       = 1'b1;
            push_entry = {1'b0, cnt_q, align_byte(sr_q, cnt_q)};
        end
`else
        push_entry = {done_now, new_cnt, aligned};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (take_bit) begin
                sr_q  <= new_sr;
                cnt_q <= full_now ? 4'd0 : new_cnt;
            end
`ifdef PACKER_CRC_EN
            if (state_q == FLUSH) begin
                state_q <= CRC;
            end else if (done_now) begin
                state_q <= (state_q == CRC) ? FLUSH : CRC;
            end else if (take_bit) begin
                state_q <= COLLECT;
            end else begin
                state_q <= IDLE;
            end
`else
            if (done_now) begin
                state_q <= IDLE;
            end else if (take_bit) begin
                state_q <= COLLECT;
            end else begin
                state_q <= IDLE;
            end
`endif
        end
    end

`ifdef PACKER_CRC_EN
    // Dropped bytes still feed the CRC: it tracks what was produced, not what was queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= '0;
        end else if (dpush) begin
            crc_q <= crc8_byte(new_pkt ? 8'h00 : crc_q, aligned);
        end else if (new_pkt) begin
            crc_q <= '0;
        end
    end
`endif

    assign fifo_vld  = (count_q != '0);
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign pop       = fifo_vld && bus.byte_ready;
    assign push_ok   = push && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push_ok && pop) begin
                count_q <= count_q - CW'(1);
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head fields are forced to zero while empty so reset and idle outputs read 0.
    assign head           = mem_q[rd_ptr_q];
    assign bus.byte_valid = fifo_vld;
    assign bus.byte_data  = fifo_vld ? head.data  : 8'h00;
    assign bus.byte_last  = fifo_vld ? head.last  : 1'b0;
    assign bus.byte_nbits = fifo_vld ? head.nbits : 4'd0;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = (state_q != IDLE) || fifo_vld;
endmodule

// File: tb/tb_huffman_byte_packer.sv
// Directed bench: dut0 pads with 0, dut1 pads with 1; outputs sampled on negedge into per-DUT queues.
module tb_huffman_byte_packer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    huffman_byte_packer_if bus0();
    huffman_byte_packer_if bus1();

    huffman_byte_packer #(.FIFO_DEPTH(8), .PAD_BIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    huffman_byte_packer #(.FIFO_DEPTH(8), .PAD_BIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [23:0]      bits;
        int               len;
        int               nexp;
        logic [2:0][12:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [12:0] rx0 [$];
    logic [12:0] rx1 [$];
    int          n_pass = 0;
    int          n_total = 0;
    logic        vb;
    logic        va;

    always @(negedge clk) begin
        if (!rst && bus0.byte_valid && bus0.byte_ready)
            rx0.push_back({bus0.byte_last, bus0.byte_nbits, bus0.byte_data});
        if (!rst && bus1.byte_valid && bus1.byte_ready)
            rx1.push_back({bus1.byte_last, bus1.byte_nbits, bus1.byte_data});
    end

    function automatic logic [12:0] ent(input logic last, input logic [3:0] nb, input logic [7:0] d);
        return {last, nb, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_vec(input int i, input logic [23:0] bits, input int len, input int nexp,
                           input logic [12:0] e0, input logic [12:0] e1, input logic [12:0] e2);
        vecs[i].bits   = bits;
        vecs[i].len    = len;
        vecs[i].nexp   = nexp;
        vecs[i].exp[0] = e0;
        vecs[i].exp[1] = e1;
        vecs[i].exp[2] = e2;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drive0(input logic b, input logic s, input logic d);
        @(posedge clk); #1;
        bus0.bit_in = b; bus0.bit_start = s; bus0.bit_done = d;
    endtask

    // bits are left-aligned in [23:..]; vb/va sample byte_valid just before and just after the final bit.
    task automatic send_pkt(input bit which, input logic [23:0] bits, input int len,
                            output logic vbo, output logic vao);
        vbo = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (which) begin
                if (i == len - 1) vbo = bus1.byte_valid;
                bus1.bit_in = bits[23-i]; bus1.bit_start = (i == 0); bus1.bit_done = (i == len - 1);
            end else begin
                if (i == len - 1) vbo = bus0.byte_valid;
                bus0.bit_in = bits[23-i]; bus0.bit_start = (i == 0); bus0.bit_done = (i == len - 1);
            end
        end
        @(posedge clk); #1;
        vao = which ? bus1.byte_valid : bus0.byte_valid;
        bus0.bit_in = 1'b0; bus0.bit_start = 1'b0; bus0.bit_done = 1'b0;
        bus1.bit_in = 1'b0; bus1.bit_start = 1'b0; bus1.bit_done = 1'b0;
    endtask

    task automatic compare_rx(input bit which, input string tag, input int nexp,
                              input logic [2:0][12:0] exp);
        int sz;
        logic [12:0] got;
        sz = which ? rx1.size() : rx0.size();
        check({tag, "_count"}, 32'(sz), 32'(nexp));
        for (int j = 0; j < nexp; j++) begin
            got = 13'h1FFF;
            if (j < sz) got = which ? rx1[j] : rx0[j];
            check($sformatf("%s_entry%0d", tag, j), 32'(got), 32'(exp[j]));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus0.bit_in = 1'b0; bus0.bit_start = 1'b0; bus0.bit_done = 1'b0; bus0.byte_ready = 1'b0;
        bus1.bit_in = 1'b0; bus1.bit_start = 1'b0; bus1.bit_done = 1'b0; bus1.byte_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus0.byte_valid), 32'd0);
        check("rst_data", 32'(bus0.byte_data), 32'd0);
        check("rst_last", 32'(bus0.byte_last), 32'd0);
        check("rst_nbits", 32'(bus0.byte_nbits), 32'd0);
        check("rst_overflow", 32'(bus0.overflow), 32'd0);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        rst = 1'b0;

`ifdef PACKER_CRC_EN
        bus0.byte_ready = 1'b1;
        rx0.delete();
        send_pkt(1'b0, {8'h01, 16'h0}, 8, vb, va);
        repeat (6) @(posedge clk);
        #1;
        compare_rx(1'b0, "crc_0x01", 2, {13'h0, ent(1'b1, 4'd8, 8'h07), ent(1'b0, 4'd8, 8'h01)});
        check("crc_busy", 32'(bus0.busy), 32'd0);
`else
        set_vec(0, {9'b101101001, 15'h0}, 9, 2, ent(1'b0, 4'd8, 8'hB4), ent(1'b1, 4'd1, 8'h80), 13'h0);
        set_vec(1, {8'h5A, 16'h0}, 8, 1, ent(1'b1, 4'd8, 8'h5A), 13'h0, 13'h0);
        set_vec(2, {1'b1, 23'h0}, 1, 1, ent(1'b1, 4'd1, 8'h80), 13'h0, 13'h0);
        set_vec(3, {3'b110, 21'h0}, 3, 1, ent(1'b1, 4'd3, 8'hC0), 13'h0, 13'h0);
        set_vec(4, {16'hA5C3, 8'h0}, 16, 2, ent(1'b0, 4'd8, 8'hA5), ent(1'b1, 4'd8, 8'hC3), 13'h0);
        set_vec(5, {12'b1111_0000_1011, 12'h0}, 12, 2, ent(1'b0, 4'd8, 8'hF0), ent(1'b1, 4'd4, 8'hB0), 13'h0);
        set_vec(6, {7'b1010101, 17'h0}, 7, 1, ent(1'b1, 4'd7, 8'hAA), 13'h0, 13'h0);
        set_vec(7, {16'hFF00, 1'b1, 7'h0}, 17, 3, ent(1'b0, 4'd8, 8'hFF), ent(1'b0, 4'd8, 8'h00),
                ent(1'b1, 4'd1, 8'h80));

        bus0.byte_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx0.delete();
            send_pkt(1'b0, vecs[i].bits, vecs[i].len, vb, va);
            repeat (5) @(posedge clk);
            #1;
            compare_rx(1'b0, $sformatf("vec%0d", i), vecs[i].nexp, vecs[i].exp);
            check($sformatf("vec%0d_busy", i), 32'(bus0.busy), 32'd0);
        end

        // Overflow: nine full-byte packets into eight entries with the consumer stalled.
        do_reset();
        bus0.byte_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            send_pkt(1'b0, {8'(8'h10 + k), 16'h0}, 8, vb, va);
            if (k == 0) begin
                check("latency_before", 32'(vb), 32'd0);
                check("latency_after", 32'(va), 32'd1);
            end
            if (k == 7) check("ovf_after8", 32'(bus0.overflow), 32'd0);
        end
        check("ovf_after9", 32'(bus0.overflow), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("stall_head_data", 32'(bus0.byte_data), 32'h10);
        check("stall_head_last", 32'(bus0.byte_last), 32'd1);
        check("stall_busy", 32'(bus0.busy), 32'd1);
        rx0.delete();
        bus0.byte_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("ovf_drain_count", 32'(rx0.size()), 32'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("ovf_drain%0d", k), (k < rx0.size()) ? 32'(rx0[k]) : 32'h1FFF,
                  32'(ent(1'b1, 4'd8, 8'(8'h10 + k))));
        check("ovf_sticky", 32'(bus0.overflow), 32'd1);

        // Full FIFO with pop and push on the same edge: push must be accepted.
        do_reset();
        bus0.byte_ready = 1'b0;
        rx0.delete();
        for (int k = 0; k < 8; k++) send_pkt(1'b0, {8'(8'h20 + k), 16'h0}, 8, vb, va);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pkt;
            pkt = 8'h28;
            @(posedge clk); #1;
            bus0.bit_in = pkt[7-i]; bus0.bit_start = (i == 0); bus0.bit_done = (i == 7);
            bus0.byte_ready = (i == 7);
        end
        @(posedge clk); #1;
        bus0.bit_in = 1'b0; bus0.bit_start = 1'b0; bus0.bit_done = 1'b0;
        check("full_pushpop_ovf", 32'(bus0.overflow), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("full_pushpop_count", 32'(rx0.size()), 32'd9);
        for (int k = 0; k < 9; k++)
            check($sformatf("full_pushpop%0d", k), (k < rx0.size()) ? 32'(rx0[k]) : 32'h1FFF,
                  32'(ent(1'b1, 4'd8, 8'(8'h20 + k))));

        // Abort: three bits then a fresh start.
        do_reset();
        bus0.byte_ready = 1'b1;
        rx0.delete();
        drive0(1'b1, 1'b1, 1'b0);
        drive0(1'b1, 1'b0, 1'b0);
        drive0(1'b1, 1'b0, 1'b0);
        send_pkt(1'b0, {8'h3C, 16'h0}, 8, vb, va);
        repeat (5) @(posedge clk);
        #1;
        compare_rx(1'b0, "abort", 1, {13'h0, 13'h0, ent(1'b1, 4'd8, 8'h3C)});

        // Reset with a queued byte and five bits of a packet collected.
        bus0.byte_ready = 1'b0;
        send_pkt(1'b0, {8'h77, 16'h0}, 8, vb, va);
        drive0(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive0(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus0.bit_in = 1'b0; bus0.bit_start = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", 32'(bus0.byte_valid), 32'd0);
        check("midrst_busy", 32'(bus0.busy), 32'd0);
        rst = 1'b0;
        bus0.byte_ready = 1'b1;
        rx0.delete();
        send_pkt(1'b0, {8'h99, 16'h0}, 8, vb, va);
        repeat (5) @(posedge clk);
        #1;
        compare_rx(1'b0, "midrst_next", 1, {13'h0, 13'h0, ent(1'b1, 4'd8, 8'h99)});

        // PAD_BIT=1 instance.
        rx1.delete();
        send_pkt(1'b1, {1'b1, 23'h0}, 1, vb, va);
        send_pkt(1'b1, {1'b0, 23'h0}, 1, vb, va);
        send_pkt(1'b1, {3'b101, 21'h0}, 3, vb, va);
        repeat (5) @(posedge clk);
        #1;
        compare_rx(1'b1, "pad1", 3, {ent(1'b1, 4'd3, 8'hBF), ent(1'b1, 4'd1, 8'h7F), ent(1'b1, 4'd1, 8'hFF)});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
